// File: rtl/apb_pkg.sv
// Shared definitions for the APB register responder: FSM encoding and address/width defaults.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam int APB_ALIGN_LSB = 2;
  localparam int AW_DEF        = 8;
  localparam int DW_DEF        = 32;

endpackage

// File: rtl/regnbr.sv
// W-bit software register with write enable and a registered one-cycle write strobe.
module regnbr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         pulse
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= we;
      if (we) q <= d;
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 completer with NREG word registers, programmable wait states and PSLVERR on bad addresses.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NREG = 8,
  parameter int WAIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic             pwrite_i,
  input  logic [AW-1:0]    paddr_i,
  input  logic [DW-1:0]    pwdata_i,
  output logic [DW-1:0]    prdata_o,
  output logic             pready_o,
  output logic             pslverr_o,
  output logic [NREG*DW-1:0] reg_o,
  output logic [NREG-1:0]  wr_pulse_o
);

  localparam int         IW     = AW - APB_ALIGN_LSB;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_t          state;
  logic [3:0]      cnt;
  logic            err_q;
  logic            pwrite_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   pwdata_q;

  logic [IW-1:0]   idx;
  logic            err_calc;
  logic            done;
  logic [DW-1:0]   rd_mux;
  logic [NREG-1:0] we;
  logic [DW-1:0]   regs_q [NREG];

  assign idx      = paddr_i[AW-1:APB_ALIGN_LSB];
  assign err_calc = (paddr_i[APB_ALIGN_LSB-1:0] != '0) || (32'(idx) >= 32'(NREG));

  assign pready_o  = (state == ST_ACCESS) && (cnt == WAIT_C);
  assign pslverr_o = pready_o && err_q;
  assign done      = pready_o && psel_i && penable_i;

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NREG; k++) begin
      if (idx == IW'(k)) rd_mux = regs_q[k];
    end
  end

  always_comb begin
    we = '0;
    for (int k = 0; k < NREG; k++) begin
      we[k] = done && pwrite_q && !err_q && (idx_q == IW'(k));
    end
  end

  // Control path: FSM, wait counter, error flag and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      err_q    <= 1'b0;
      prdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Setup phase only; PENABLE already high in IDLE is a protocol violation and is ignored
          if (psel_i && !penable_i) begin
            state    <= ST_ACCESS;
            cnt      <= '0;
            err_q    <= err_calc;
            prdata_o <= (!pwrite_i && !err_calc) ? rd_mux : '0;
          end
        end
        ST_ACCESS: begin
          if (psel_i && penable_i) begin
            if (cnt < WAIT_C) begin
              cnt <= cnt + 4'd1;
            end else begin
              state    <= ST_IDLE;
              prdata_o <= '0;
            end
          end else begin
            state    <= ST_IDLE;
            prdata_o <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Captured transfer attributes; only consumed while in ACCESS
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && psel_i && !penable_i) begin
      idx_q    <= idx;
      pwrite_q <= pwrite_i;
      pwdata_q <= pwdata_i;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    regnbr #(.W(DW)) u_reg (
      .clk   (clk),
      .rst   (rst),
      .we    (we[k]),
      .d     (pwdata_q),
      .q     (regs_q[k]),
      .pulse (wr_pulse_o[k])
    );
    assign reg_o[k*DW +: DW] = regs_q[k];
  end

endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
APB3 responder (completer) holding a bank of NREG software-visible DW-bit registers. It is the target end of the APB interface driven by the bridge's APB master side. It decodes word addresses, inserts a programmable number of wait states, and flags misaligned or out-of-range accesses with PSLVERR. Register contents are exported flat to hardware, together with per-register write strobes.

Parameters:
AW, 8, APB address width; the word index is paddr[AW-1:2].
DW, 32, data width of PWDATA, PRDATA and each register.
NREG, 8, number of registers; must satisfy 1 <= NREG <= 2^(AW-2).
WAIT, 0, wait states inserted per transfer; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
psel_i  in  1  APB PSEL.
penable_i  in  1  APB PENABLE.
pwrite_i  in  1  APB PWRITE (1 = write).
paddr_i  in  AW  APB PADDR (byte address).
pwdata_i  in  DW  APB PWDATA.
prdata_o  out  DW  APB PRDATA; registered.
pready_o  out  1  APB PREADY.
pslverr_o  out  1  APB PSLVERR; valid only while pready_o=1.
reg_o  out  NREG*DW  register contents; register k is on bits [k*DW +: DW].
wr_pulse_o  out  NREG  one-cycle pulse on the cycle register k is written; registered.

Behaviour:
- Reset, taking priority over everything else:
  - state=IDLE, counter=0.
  - All registers are 0, so reg_o=0.
  - prdata_o=0, pready_o=0, pslverr_o=0, wr_pulse_o=0.
  - Reset during an open transfer discards it with no write.
- FSM states: IDLE and ACCESS. A 4-bit counter cnt tracks wait states.
- IDLE:
  - If psel_i=1 and penable_i=0 (setup phase), capture paddr_i, pwrite_i and pwdata_i, then go to ACCESS with cnt=0.
  - err_q is computed at this point: err_q = (paddr_i[1:0] != 0) or (paddr_i[AW-1:2] >= NREG).
  - On a read, prdata_o loads reg[index], or 0 if err_q=1. On a write, prdata_o loads 0.
  - psel_i=1 together with penable_i=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - pready_o = (state==ACCESS) and (cnt==WAIT), decoded combinationally from registered state.
  - If psel_i=1, penable_i=1 and cnt<WAIT: increment cnt.
  - If psel_i=1, penable_i=1 and cnt==WAIT (completion cycle):
    - pready_o=1 and pslverr_o=err_q.
    - Write with err_q=0: at the closing edge, reg[index] <= captured pwdata, and wr_pulse_o[index]=1 for the following cycle.
    - Write with err_q=1: no register changes.
    - Next state is IDLE. prdata_o clears to 0 at the closing edge.
  - If psel_i=0 or penable_i=0 (abort): return to IDLE, no write, prdata_o cleared to 0.
- Latency: WAIT=0 gives a zero-wait transfer, i.e. setup cycle plus one access cycle. Each unit of WAIT adds one cycle.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted, because the state is IDLE in that cycle.
- wr_pulse_o is 0 in every cycle not immediately following a committed write.
- Inputs pwdata_i and paddr_i are ignored outside the setup cycle; the captured copies are used.

Decomposition:
- Shared package (apb_pkg):
  - State encodings ST_IDLE and ST_ACCESS.
  - APB_ALIGN_LSB=2.
  - Default widths AW_DEF=8 and DW_DEF=32.
- One natural sub-module: regnbr, an N-bit register with synchronous active-high reset and write enable. It is instantiated NREG times via generate, and the wr_pulse flop lives inside it.
- FSM, counter, decode and prdata mux stay in the top level.

Test Plan:
- Reset: hold rst high 3 cycles mid-write to addr 0x04 -> reg_o all zero, pready_o=0, pslverr_o=0, wr_pulse_o=0, and no write occurs after reset releases.
- Write/read, WAIT=0: write 0xDEADBEEF to 0x08, then read 0x08 -> pready_o=1 in the second cycle of each transfer, reg_o[2*32+:32]=0xDEADBEEF, wr_pulse_o=8'b0000_0100 for one cycle, prdata_o=0xDEADBEEF with pslverr_o=0.
- Wait states, WAIT=3: read 0x00 -> pready_o low for 3 access cycles, then high for exactly 1 cycle; total transfer is 5 cycles.
- Errors: write 0x20 (index 8 >= NREG) and write 0x05 (misaligned) -> pslverr_o=1 with pready_o=1, reg_o unchanged, wr_pulse_o stays 0. Read of 0x20 -> prdata_o=0, pslverr_o=1.
- Abort: setup write to 0x0C, then drop psel_i in the access phase with WAIT=2 -> FSM returns to IDLE, reg 3 unchanged, no pulse.
- Back-to-back: write 0x00=1, read 0x00, write 0x1C=0xFFFFFFFF in consecutive transfers -> each completes, the read returns 1, and reg 7 = 0xFFFFFFFF.
